// File: rtl/fixed_point_sqrt_iter_if.sv
// Handshake and data bundle for the iterative fixed-point square root unit.
// The master drives the operand and start strobe; the slave (the unit) returns
// busy, the completion pulse, the root and the negative-operand flag.
interface fixed_point_sqrt_iter_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic [WIDTH-1:0] Operand;
  logic             iInputReady;
  logic             oBusy;
  logic             OutputReady;
  logic [WIDTH-1:0] Result;
  logic             oNegative;

  modport master (
    output Operand,
    output iInputReady,
    input  oBusy,
    input  OutputReady,
    input  Result,
    input  oNegative
  );

  modport slave (
    input  Operand,
    input  iInputReady,
    output oBusy,
    output OutputReady,
    output Result,
    output oNegative
  );

endinterface

// File: rtl/fixed_point_sqrt_iter.sv
// Exact fixed-point square root, radix-2 restoring digit recurrence, one root
// bit per cycle. Result = floor(sqrt(Operand * 2^SCALE)) in the same format.
// Optional macro SQRT_ROUND_TO_NEAREST_EN adds a final rounding state
// (Result = Q+1 when remainder > Q), costing one extra cycle of latency.
module fixed_point_sqrt_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SCALE = 17
) (
  input logic                    Clock,
  input logic                    Reset,
  fixed_point_sqrt_iter_if.slave bus
);

  localparam int unsigned RW = (WIDTH + SCALE + 1) / 2;  // root bits
  localparam int unsigned N  = RW;                       // iterations
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StRound} stateT;

  stateT             stateQ, stateD;
  logic [2*RW-1:0]   radQ, radD;      // radicand, consumed two bits per cycle from the MSB end
  logic [RW+1:0]     remQ, remD;      // partial remainder P
  logic [RW-1:0]     rootQ, rootD;    // partial root Q
  logic [CW-1:0]     cntQ, cntD;
  logic              negQ, negD;
  logic [WIDTH-1:0]  resultQ, resultD;
  logic              doneQ, doneD;
  logic              negOutQ, negOutD;

  logic [RW+1:0]     trial;
  logic [RW+2:0]     diff;

  // Trial remainder and its difference against (Q << 2) | 1; diff MSB is the borrow.
  always_comb begin
    trial = (remQ << 2) | (RW + 2)'(radQ[2*RW-1 -: 2]);
    diff  = {1'b0, trial} - {1'b0, rootQ, 2'b01};
  end

`ifdef SQRT_ROUND_TO_NEAREST_EN
  logic [RW:0] rounded;

  // Round to nearest: remainder above Q means sqrt lies beyond Q + 0.5.
  always_comb begin
    rounded = {1'b0, rootQ} + (RW + 1)'(remQ > (RW + 2)'(rootQ));
  end
`endif

  // Next-state and datapath control.
  always_comb begin
    stateD  = stateQ;
    radD    = radQ;
    remD    = remQ;
    rootD   = rootQ;
    cntD    = cntQ;
    negD    = negQ;
    resultD = resultQ;
    doneD   = 1'b0;
    negOutD = negOutQ;

    unique case (stateQ)
      StIdle: begin
        if (bus.iInputReady) begin
          radD   = (2 * RW)'(bus.Operand) << SCALE;
          remD   = '0;
          rootD  = '0;
          cntD   = CW'(N - 1);
          negD   = bus.Operand[WIDTH-1];
          stateD = StCalc;
        end
      end
      StCalc: begin
        radD  = radQ << 2;
        remD  = diff[RW+2] ? trial : diff[RW+1:0];
        rootD = {rootQ[RW-2:0], ~diff[RW+2]};
        cntD  = cntQ - 1'b1;
        if (cntQ == '0) begin
`ifdef SQRT_ROUND_TO_NEAREST_EN
          stateD  = StRound;
`else
          stateD  = StIdle;
          doneD   = 1'b1;
          resultD = negQ ? '0 : WIDTH'(rootD);
          negOutD = negQ;
`endif
        end
      end
      StRound: begin
        stateD  = StIdle;
        doneD   = 1'b1;
`ifdef SQRT_ROUND_TO_NEAREST_EN
        resultD = negQ ? '0 : WIDTH'(rounded);
`else
        resultD = negQ ? '0 : WIDTH'(rootQ);
`endif
        negOutD = negQ;
      end
      default: stateD = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset; reset aborts any operation.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stateQ  <= StIdle;
      radQ    <= '0;
      remQ    <= '0;
      rootQ   <= '0;
      cntQ    <= '0;
      negQ    <= 1'b0;
      resultQ <= '0;
      doneQ   <= 1'b0;
      negOutQ <= 1'b0;
    end else begin
      stateQ  <= stateD;
      radQ    <= radD;
      remQ    <= remD;
      rootQ   <= rootD;
      cntQ    <= cntD;
      negQ    <= negD;
      resultQ <= resultD;
      doneQ   <= doneD;
      negOutQ <= negOutD;
    end
  end

  assign bus.oBusy       = (stateQ != StIdle);
  assign bus.OutputReady = doneQ;
  assign bus.Result      = resultQ;
  assign bus.oNegative   = negOutQ;

endmodule
